// File: rtl/clock_disp.sv
// Clock display: a 24-hour time of day kept in registers, with hold/set loading,
// and a six-digit multiplexed seven-segment drive with field blinking.
module clock_disp #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] stop_clk,
  input  logic [3:0] h,
  input  logic [3:0] m,
  input  logic [3:0] s,
  input  logic [5:0] hou,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] show_hou,
  output logic [5:0] show_min,
  output logic [5:0] show_sec,
  output logic       sec_tick,
  output logic [7:0] seg_out,
  output logic [5:0] dig_sel
);

  localparam int HALF = TICK_DIV / 2;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic [2:0]    dig_idx;
  logic          disp_en;

  logic       hold, tick, scan_wrap;
  logic [5:0] sec_nx, min_nx, hou_nx;
  logic [5:0] hou_ld, min_ld, sec_ld;
  logic [5:0] fld;
  logic [3:0] digit;
  logic       sel_h, sel_m, sel_s, blank;
  logic [7:0] seg_nx;
  logic [5:0] dig_nx;

  // Only bit 0 of each field-select input carries meaning.
  logic unused_sel_bits;
  assign unused_sel_bits = ^{h[3:1], m[3:1], s[3:1]};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign hold      = |stop_clk;
  assign tick      = !hold && (presc == PRESC_MAX);
  assign scan_wrap = (scan_cnt == SCAN_MAX);

  assign hou_ld = (hou > 6'd23) ? 6'd0 : hou;
  assign min_ld = (min > 6'd59) ? 6'd0 : min;
  assign sec_ld = (sec > 6'd59) ? 6'd0 : sec;

  always_comb begin
    sec_nx = show_sec + 6'd1;
    min_nx = show_min;
    hou_nx = show_hou;
    if (show_sec == 6'd59) begin
      sec_nx = 6'd0;
      if (show_min == 6'd59) begin
        min_nx = 6'd0;
        hou_nx = (show_hou == 6'd23) ? 6'd0 : show_hou + 6'd1;
      end else begin
        min_nx = show_min + 6'd1;
      end
    end
  end

  // Blanking needs exactly one field flag; zero or several means none blinks.
  assign sel_h = h[0] && !m[0] && !s[0];
  assign sel_m = m[0] && !h[0] && !s[0];
  assign sel_s = s[0] && !h[0] && !m[0];

  always_comb begin
    fld   = show_sec;
    blank = 1'b0;
    if (dig_idx < 3'd2)      fld = show_hou;
    else if (dig_idx < 3'd4) fld = show_min;
    digit = dig_idx[0] ? 4'(fld % 6'd10) : 4'(fld / 6'd10);
    if (hold && blink_ph) begin
      blank = (sel_h && dig_idx < 3'd2) ||
              (sel_m && (dig_idx == 3'd2 || dig_idx == 3'd3)) ||
              (sel_s && dig_idx >= 3'd4);
    end
    seg_nx = {1'b1, seg7(digit)};
    if ((dig_idx == 3'd1 || dig_idx == 3'd3) && !blink_ph) seg_nx[7] = 1'b0;
    if (blank) seg_nx = 8'hFF;
    dig_nx = ~(6'b000001 << dig_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      show_hou <= 6'd12;
      show_min <= 6'd46;
      show_sec <= 6'd57;
    end else if (hold) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      show_hou <= hou_ld;
      show_min <= min_ld;
      show_sec <= sec_ld;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      sec_tick <= tick;
      if (tick) begin
        show_hou <= hou_nx;
        show_min <= min_nx;
        show_sec <= sec_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      dig_idx   <= 3'd0;
      disp_en   <= 1'b0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) begin
        dig_idx <= (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
        disp_en <= 1'b1;
      end
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink_ph  <= !blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // The drive stays dark until the first scan wrap has moved the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= 8'hFF;
      dig_sel <= 6'h3F;
    end else if (disp_en) begin
      seg_out <= seg_nx;
      dig_sel <= dig_nx;
    end
  end

endmodule

// File: tb/tb_clock_disp.sv
// Self-checking bench for clock_disp: a time-of-day model in whole seconds with
// scan and blink phase derived arithmetically from the cycle count since reset.
module tb_clock_disp;

  localparam int TD = 10;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] stop_clk = 4'd0;
  logic [3:0] h = 4'd0, m = 4'd0, s = 4'd0;
  logic [5:0] hou = 6'd0, min = 6'd0, sec = 6'd0;
  logic [5:0] show_hou, show_min, show_sec;
  logic       sec_tick;
  logic [7:0] seg_out;
  logic [5:0] dig_sel;

  clock_disp #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .stop_clk(stop_clk), .h(h), .m(m), .s(s),
    .hou(hou), .min(min), .sec(sec), .show_hou(show_hou), .show_min(show_min),
    .show_sec(show_sec), .sec_tick(sec_tick), .seg_out(seg_out), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // model state
  int t_m = 0;        // seconds of day
  int k_m = 0;        // edges since reset
  int r_m = 0;        // run cycles since last second boundary
  bit tick_m = 0;
  logic [7:0] seg_m = 8'hFF;
  logic [5:0] dig_m = 6'h3F;
  int tick_seen;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int pre_t, pre_k, idx, ph, f, d, nsel, hs, ms, ss;
    logic [7:0] code;
    pre_t = t_m;
    pre_k = k_m;
    @(posedge clk);
    if (rst) begin
      t_m = 12*3600 + 46*60 + 57;
      k_m = 0; r_m = 0; tick_m = 0;
      seg_m = 8'hFF; dig_m = 6'h3F;
    end else begin
      if (pre_k >= SD) begin
        idx = (pre_k / SD) % 6;
        ph  = (pre_k / (TD/2)) % 2;
        if (idx < 2)      f = pre_t / 3600;
        else if (idx < 4) f = (pre_t / 60) % 60;
        else              f = pre_t % 60;
        d = (idx % 2 == 0) ? f / 10 : f % 10;
        code = seg_tab[d];
        if ((idx == 1 || idx == 3) && ph == 0) code = code & 8'h7F;
        nsel = int'(h[0]) + int'(m[0]) + int'(s[0]);
        if (stop_clk != 0 && ph == 1 && nsel == 1 &&
            ((h[0] && idx < 2) || (m[0] && (idx == 2 || idx == 3)) || (s[0] && idx >= 4)))
          code = 8'hFF;
        seg_m = code;
        dig_m = 6'h3F & ~(6'd1 << idx);
      end
      if (stop_clk != 0) begin
        hs = (hou > 23) ? 0 : int'(hou);
        ms = (min > 59) ? 0 : int'(min);
        ss = (sec > 59) ? 0 : int'(sec);
        t_m = hs*3600 + ms*60 + ss;
        r_m = 0; tick_m = 0;
      end else begin
        tick_m = (r_m == TD-1);
        if (tick_m) t_m = (t_m + 1) % 86400;
        r_m = (r_m + 1) % TD;
      end
      k_m++;
    end
    @(negedge clk);
    chk("show_hou", show_hou, t_m / 3600);
    chk("show_min", show_min, (t_m / 60) % 60);
    chk("show_sec", show_sec, t_m % 60);
    chk("sec_tick", sec_tick, tick_m);
    chk("seg_out", seg_out, seg_m);
    chk("dig_sel", dig_sel, dig_m);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    run(2);
    chk("rst_hou", show_hou, 12);
    chk("rst_min", show_min, 46);
    chk("rst_sec", show_sec, 57);
    chk("rst_seg", seg_out, 8'hFF);
    chk("rst_dig", dig_sel, 6'h3F);
    chk("rst_tick", sec_tick, 0);
    rst = 1'b0;

    // free run from 12:46:57 through several scans and a minute carry
    run(90);

    // 23:59:59 rollover, tick exactly TD cycles after hold released
    stop_clk = 4'd1; hou = 23; min = 59; sec = 59;
    run(3);
    stop_clk = 4'd0;
    tick_seen = 0;
    for (int i = 1; i <= TD; i++) begin
      cycle();
      if (sec_tick) tick_seen = tick_seen + (i == TD ? 1 : 100);
    end
    chk("rollover_tick", tick_seen, 1);
    chk("rollover_time", {show_hou, show_min, show_sec}, 18'd0);

    // out-of-range loads clear only the offending fields
    stop_clk = 4'd8; hou = 63; min = 5; sec = 60;
    run(2);
    chk("oor_hou", show_hou, 0);
    chk("oor_min", show_min, 5);
    chk("oor_sec", show_sec, 0);

    // minute blink, then two flags together (no blanking)
    hou = 12; min = 46; sec = 57; m = 4'd1;
    run(30);
    h = 4'd1;
    run(20);
    h = 4'd0; m = 4'd0; s = 4'd1;
    run(15);
    s = 4'd0;

    // stop asserted on the tick cycle: load wins
    stop_clk = 4'd0; hou = 10; min = 59; sec = 59;
    run(5);
    for (int i = 0; i < 20 && r_m != TD-1; i++) cycle();
    stop_clk = 4'd2; hou = 10; min = 59; sec = 59;
    cycle();
    chk("collide_tick", sec_tick, 0);
    chk("collide_sec", show_sec, 59);
    stop_clk = 4'd0;
    run(25);

    // reset mid-count at prescaler 6
    for (int i = 0; i < 20 && r_m != 6; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_time", {show_hou, show_min, show_sec}, {6'd12, 6'd46, 6'd57});
    tick_seen = 0;
    for (int i = 1; i <= TD; i++) begin
      cycle();
      if (sec_tick) tick_seen = tick_seen + (i == TD ? 1 : 100);
    end
    chk("midrst_tick", tick_seen, 1);

    // randomized bursts of hold/run with random loads, flags and rare resets
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(3, 25);
      stop_clk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      h = 4'($urandom_range(0, 15));
      m = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) begin
        hou = 6'($urandom_range(0, 30));
        min = 6'($urandom_range(0, 63));
        sec = 6'($urandom_range(0, 63));
        rst = ($urandom_range(0, 59) == 0);
        cycle();
      end
      rst = 1'b0;
    end
    stop_clk = 4'd0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
